// File: rtl/id_hazard_scoreboard_pkg.sv
// id_hazard_scoreboard_pkg
//   Shared types and constants for the decode-stage hazard scoreboard.
//   sb_entry_t : one in-flight instruction {valid, wb, mem_r, s, dest}
//   STG_*      : scoreboard index of each downstream pipeline stage
//   SB_BUBBLE  : the all-zero entry loaded when nothing issues
package id_hazard_scoreboard_pkg;

    typedef struct packed {
        logic       valid;  // entry holds a real instruction
        logic       wb;     // writes the register file
        logic       mem_r;  // is a load
        logic       s;      // updates the status register
        logic [3:0] dest;   // destination register index
    } sb_entry_t;

    localparam int STG_EXE = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;
    localparam int NUM_STG = 3;

    localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/id_hazard_scoreboard_sb_entry_match.sv
// sb_entry_match
//   Combinational RAW comparator for one scoreboard entry.
//   Ports:
//     valid, wb, dest : fields of the pending entry
//     src1, src2      : register indices read by the ID instruction
//     two_src         : ID instruction actually reads src2
//     match           : pending write targets a register ID reads
module sb_entry_match (
    input  logic       valid,
    input  logic       wb,
    input  logic [3:0] dest,
    input  logic [3:0] src1,
    input  logic [3:0] src2,
    input  logic       two_src,
    output logic       match
);

    // Both sources hitting the same entry collapse into one match bit.
    assign match = valid & wb & ((dest == src1) | (two_src & (dest == src2)));

endmodule

// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard
//   Decode-stage hazard controller. Tracks writes in flight in EXE, MEM
//   and WB and raises hazard when the ID instruction would read a stale
//   register or status value. On a hazard IF/ID stalls and a bubble
//   enters EXE. Also counts hazard cycles (saturating).
//   Ports:
//     clk, rst        : rising-edge clock, synchronous active-high reset
//     freeze          : memory stall, holds all state
//     flush           : branch taken, ID instruction is invalid
//     id_*, src1/2    : decoded fields of the instruction in ID
//     two_src         : ID reads src2
//     hazard          : stall IF/ID, bubble EXE (combinational)
//     pend_valid      : valid bits of {WB, MEM, EXE} entries
//     stall_count     : saturating count of non-frozen hazard cycles
module id_hazard_scoreboard
    import id_hazard_scoreboard_pkg::*;
#(
    parameter bit FORWARD_EN = 1'b0,
    parameter bit WB_BYPASS  = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             two_src,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic             id_s,
    input  logic             id_uses_status,
    input  logic [3:0]       id_dest,
    output logic             hazard,
    output logic [2:0]       pend_valid,
    output logic [CNT_W-1:0] stall_count
);

    sb_entry_t          ent [NUM_STG];
    logic [NUM_STG-1:0] m;
    logic               raw;
    logic               sh;
    logic               issue;

    for (genvar g = 0; g < NUM_STG; g++) begin : g_match
        sb_entry_match u_match (
            .valid   (ent[g].valid),
            .wb      (ent[g].wb),
            .dest    (ent[g].dest),
            .src1    (src1),
            .src2    (src2),
            .two_src (two_src),
            .match   (m[g])
        );
    end

    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        raw = 1'b0;
        if (FORWARD_EN) begin
            // With forwarding only a load result in EXE is not yet available.
            raw = m[STG_EXE] & ent[STG_EXE].mem_r;
        end else begin
            raw = m[STG_EXE] | m[STG_MEM] | (m[STG_WB] & ~WB_BYPASS);
        end
    end

    // Status is written at the end of EXE, so forwarding never covers it.
    assign sh     = id_uses_status & ent[STG_EXE].valid & ent[STG_EXE].s;
    assign hazard = id_valid & ~flush & (raw | sh);
    assign issue  = id_valid & ~flush & ~hazard;

    assign pend_valid = {ent[STG_WB].valid, ent[STG_MEM].valid, ent[STG_EXE].valid};

    // NOTE: sequential state uses non-blocking assignments so the shift
    // E0 -> E1 -> E2 reads the pre-edge values of every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_STG; i++) begin
                ent[i] <= SB_BUBBLE;
            end
            stall_count <= '0;
        end else if (!freeze) begin
            ent[STG_WB]  <= ent[STG_MEM];
            ent[STG_MEM] <= ent[STG_EXE];
            if (issue) begin
                ent[STG_EXE] <= '{valid: 1'b1, wb: id_wb_en, mem_r: id_mem_r_en,
                                  s: id_s, dest: id_dest};
            end else begin
                ent[STG_EXE] <= SB_BUBBLE;
            end
            if (hazard && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb_id_hazard_scoreboard
//   Four scoreboard instances with different parameters, each driven by
//   its own stimulus record:
//     0: FORWARD_EN=0 WB_BYPASS=0 CNT_W=16
//     1: FORWARD_EN=0 WB_BYPASS=1 CNT_W=16
//     2: FORWARD_EN=1 WB_BYPASS=0 CNT_W=16
//     3: FORWARD_EN=0 WB_BYPASS=0 CNT_W=2
//   The stimulus pushes hand-computed expectations tagged with the cycle
//   they apply to; a monitor pops and compares them on the falling edge.
module tb_id_hazard_scoreboard;

    typedef struct packed {
        logic       rst;
        logic       freeze;
        logic       flush;
        logic       id_valid;
        logic [3:0] src1;
        logic [3:0] src2;
        logic       two_src;
        logic       id_wb_en;
        logic       id_mem_r_en;
        logic       id_s;
        logic       id_uses_status;
        logic [3:0] id_dest;
    } stim_t;

    typedef struct {
        int         cyc;
        int         d;
        logic       hz;
        logic [2:0] pv;
        int         cnt;
        string      name;
    } exp_t;

    logic        clk = 1'b0;
    stim_t       st [4];
    logic        hz [4];
    logic [2:0]  pv [4];
    logic [15:0] sc [4];

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam bit F = (g == 2);
        localparam bit B = (g == 1);
        localparam int W = (g == 3) ? 2 : 16;
        logic [W-1:0] cnt;

        id_hazard_scoreboard #(.FORWARD_EN(F), .WB_BYPASS(B), .CNT_W(W)) dut (
            .clk            (clk),
            .rst            (st[g].rst),
            .freeze         (st[g].freeze),
            .flush          (st[g].flush),
            .id_valid       (st[g].id_valid),
            .src1           (st[g].src1),
            .src2           (st[g].src2),
            .two_src        (st[g].two_src),
            .id_wb_en       (st[g].id_wb_en),
            .id_mem_r_en    (st[g].id_mem_r_en),
            .id_s           (st[g].id_s),
            .id_uses_status (st[g].id_uses_status),
            .id_dest        (st[g].id_dest),
            .hazard         (hz[g]),
            .pend_valid     (pv[g]),
            .stall_count    (cnt)
        );
        assign sc[g] = 16'(cnt);
    end

    function automatic stim_t ins(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                                  input logic wb, input logic mr, input logic s,
                                  input logic us, input logic [3:0] dest);
        stim_t r;
        r                = '0;
        r.id_valid       = 1'b1;
        r.src1           = s1;
        r.src2           = s2;
        r.two_src        = two;
        r.id_wb_en       = wb;
        r.id_mem_r_en    = mr;
        r.id_s           = s;
        r.id_uses_status = us;
        r.id_dest        = dest;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input int d, input logic h, input logic [2:0] p,
                              input int c, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.d    = d;
        e.hz   = h;
        e.pv   = p;
        e.cnt  = c;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic drain(input int d);
        st[d] = '0;
        repeat (3) tick();
    endtask

    // Monitor: compares every expectation due in the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                if (e.cyc < cyc) begin
                    tests++;
                    fails++;
                    $display("FAIL %s dut%0d: checked in cycle %0d, required cycle %0d",
                             e.name, e.d, cyc, e.cyc);
                    continue;
                end
                tests++;
                if (hz[e.d] !== e.hz) begin
                    fails++;
                    $display("FAIL %s dut%0d hazard: got %b, expected %b", e.name, e.d, hz[e.d], e.hz);
                end
                tests++;
                if (pv[e.d] !== e.pv) begin
                    fails++;
                    $display("FAIL %s dut%0d pend_valid: got %b, expected %b", e.name, e.d, pv[e.d], e.pv);
                end
                tests++;
                if (sc[e.d] !== 16'(e.cnt)) begin
                    fails++;
                    $display("FAIL %s dut%0d stall_count: got %0d, expected %0d", e.name, e.d, sc[e.d], e.cnt);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 4; d++) begin
            st[d]     = '0;
            st[d].rst = 1'b1;
        end
        tick();
        tick();
        for (int d = 0; d < 4; d++) st[d].rst = 1'b0;
        for (int d = 0; d < 4; d++) expect_now(d, 0, 3'b000, 0, "reset");
        tick();

        // ADD R1 then SUB reading R1, no forwarding: three stall cycles.
        st[0] = ins(2, 3, 1, 1, 0, 0, 0, 1); expect_now(0, 0, 3'b000, 0, "t1_add");  tick();
        st[0] = ins(1, 4, 1, 1, 0, 0, 0, 5); expect_now(0, 1, 3'b001, 0, "t1_c1");   tick();
        expect_now(0, 1, 3'b010, 1, "t1_c2"); tick();
        expect_now(0, 1, 3'b100, 2, "t1_c3"); tick();
        expect_now(0, 0, 3'b000, 3, "t1_c4"); tick();
        st[0] = '0; expect_now(0, 0, 3'b001, 3, "t1_sub_exe"); tick();
        drain(0);

        // Same with WB bypass: the WB entry no longer stalls.
        st[1] = ins(2, 3, 1, 1, 0, 0, 0, 1); expect_now(1, 0, 3'b000, 0, "t2_byp_add"); tick();
        st[1] = ins(1, 4, 1, 1, 0, 0, 0, 5); expect_now(1, 1, 3'b001, 0, "t2_byp_c1");  tick();
        expect_now(1, 1, 3'b010, 1, "t2_byp_c2"); tick();
        expect_now(1, 0, 3'b100, 2, "t2_byp_c3"); tick();
        st[1] = '0; expect_now(1, 0, 3'b001, 2, "t2_byp_sub_exe"); tick();
        drain(1);

        // Forwarding: an ALU producer never stalls.
        st[2] = ins(2, 3, 1, 1, 0, 0, 0, 1); expect_now(2, 0, 3'b000, 0, "t2_fwd_add"); tick();
        st[2] = ins(1, 4, 1, 1, 0, 0, 0, 5); expect_now(2, 0, 3'b001, 0, "t2_fwd_sub"); tick();
        st[2] = '0; expect_now(2, 0, 3'b011, 0, "t2_fwd_both"); tick();
        drain(2);

        // Forwarding: a load producer stalls exactly one cycle.
        st[2] = ins(2, 3, 1, 1, 1, 0, 0, 1); expect_now(2, 0, 3'b000, 0, "t2_ldr");    tick();
        st[2] = ins(1, 4, 1, 1, 0, 0, 0, 5); expect_now(2, 1, 3'b001, 0, "t2_ldr_c1"); tick();
        expect_now(2, 0, 3'b010, 1, "t2_ldr_c2"); tick();
        st[2] = '0; expect_now(2, 0, 3'b101, 1, "t2_ldr_sub_exe"); tick();
        drain(2);

        // R15 as destination, both sources on the same entry.
        st[1] = ins(0, 0, 0, 1, 1, 0, 0, 15);  expect_now(1, 0, 3'b000, 2, "r15_wr"); tick();
        st[1] = ins(15, 15, 1, 1, 0, 0, 0, 4); expect_now(1, 1, 3'b001, 2, "r15_c1"); tick();
        expect_now(1, 1, 3'b010, 3, "r15_c2"); tick();
        expect_now(1, 0, 3'b100, 4, "r15_c3"); tick();
        st[1] = '0; expect_now(1, 0, 3'b001, 4, "r15_exe"); tick();
        drain(1);

        // CMP then MOVEQ: one status stall; the CMP entry (wb=0, dest=0)
        // must not match the MOVEQ reading R0.
        st[0] = ins(1, 2, 1, 0, 0, 1, 0, 0); expect_now(0, 0, 3'b000, 3, "t3_cmp");   tick();
        st[0] = ins(0, 0, 0, 1, 0, 0, 1, 3); expect_now(0, 1, 3'b001, 3, "t3_moveq"); tick();
        expect_now(0, 0, 3'b010, 4, "t3_dest0_nomatch"); tick();
        st[0] = '0; expect_now(0, 0, 3'b101, 4, "t3_issued"); tick();
        drain(0);

        // CMP then unconditional MOV: no stall.
        st[0] = ins(1, 2, 1, 0, 0, 1, 0, 0); expect_now(0, 0, 3'b000, 4, "t3b_cmp"); tick();
        st[0] = ins(0, 0, 0, 1, 0, 0, 0, 3); expect_now(0, 0, 3'b001, 4, "t3b_mov"); tick();
        st[0] = '0; expect_now(0, 0, 3'b011, 4, "t3b_issued"); tick();
        drain(0);

        // Freeze for 4 cycles over an R2 dependency; the reader has wb=0.
        st[0] = ins(7, 0, 0, 1, 0, 0, 0, 2); expect_now(0, 0, 3'b000, 4, "t4_mov_r2"); tick();
        st[0] = ins(3, 2, 1, 0, 0, 0, 0, 0);
        st[0].freeze = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_now(0, 1, 3'b001, 4, "t4_frozen");
            tick();
        end
        st[0].freeze = 1'b0;
        expect_now(0, 1, 3'b001, 4, "t4_release"); tick();
        expect_now(0, 1, 3'b010, 5, "t4_c6"); tick();
        expect_now(0, 1, 3'b100, 6, "t4_c7"); tick();
        expect_now(0, 0, 3'b000, 7, "t4_c8"); tick();
        st[0] = '0; expect_now(0, 0, 3'b001, 7, "t4_issued"); tick();
        drain(0);

        // Flush with a matching ID instruction: no hazard, bubble enters.
        st[0] = ins(7, 0, 0, 1, 0, 0, 0, 2); expect_now(0, 0, 3'b000, 7, "t5_mov_r2"); tick();
        st[0] = ins(2, 0, 0, 1, 0, 0, 0, 6);
        st[0].flush = 1'b1;
        expect_now(0, 0, 3'b001, 7, "t5_flush"); tick();
        st[0] = '0; expect_now(0, 0, 3'b010, 7, "t5_bubble"); tick();
        drain(0);

        // 2-bit counter: dependency chain saturates, then a mid-stall reset.
        st[3] = ins(0, 0, 0, 1, 0, 0, 0, 1); expect_now(3, 0, 3'b000, 0, "t6_i1"); tick();
        st[3] = ins(1, 0, 0, 1, 0, 0, 0, 2); expect_now(3, 1, 3'b001, 0, "t6_c1"); tick();
        expect_now(3, 1, 3'b010, 1, "t6_c2"); tick();
        expect_now(3, 1, 3'b100, 2, "t6_c3"); tick();
        expect_now(3, 0, 3'b000, 3, "t6_c4"); tick();
        st[3] = ins(2, 0, 0, 1, 0, 0, 0, 3); expect_now(3, 1, 3'b001, 3, "t6_c5"); tick();
        st[3].rst = 1'b1; expect_now(3, 1, 3'b010, 3, "t6_sat"); tick();
        st[3].rst = 1'b0; expect_now(3, 0, 3'b000, 0, "t6_after_rst"); tick();

        // Flush together with freeze holds state; flush stays until freeze drops.
        st[3] = ins(3, 0, 0, 0, 0, 0, 0, 0);
        st[3].flush  = 1'b1;
        st[3].freeze = 1'b1;
        expect_now(3, 0, 3'b001, 0, "t6_flush_freeze"); tick();
        st[3].freeze = 1'b0;
        expect_now(3, 0, 3'b001, 0, "t6_flush_held"); tick();
        st[3] = '0; expect_now(3, 0, 3'b010, 0, "t6_flush_bubble"); tick();

        tick();
        tick();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
Pipeline hazard controller for the decode stage. It tracks the register-file writes and status-register writes still in flight in EXE, MEM and WB, and raises the decode-stage Hazard input when the instruction in ID would read a stale Rn, Rm or status value. On a hazard it stalls IF/ID and inserts a bubble into EXE. It also honours a global memory freeze and a branch flush, and keeps a saturating stall counter for performance measurement.

Parameters:
FORWARD_EN, 0, 1 = a forwarding unit exists; only a load in EXE causes a RAW stall.
WB_BYPASS, 0, 1 = the register file writes early enough that the WB-stage entry never causes a stall.
CNT_W, 16, width of stall_count.

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  synchronous active-high reset
freeze  in  1  memory stall; holds all pipeline state
flush  in  1  branch taken in EXE; the ID instruction is invalid this cycle
id_valid  in  1  ID holds a real instruction
src1  in  4  Rn index (Instruction[19:16])
src2  in  4  Rm index, or Rd index for stores
two_src  in  1  instruction reads src2 (register operand or store)
id_wb_en  in  1  ID instruction writes the register file
id_mem_r_en  in  1  ID instruction is a load
id_s  in  1  ID instruction updates the status register
id_uses_status  in  1  condition field is not AL
id_dest  in  4  ID destination register
hazard  out  1  stall IF/ID and bubble EXE
pend_valid  out  3  valid bits of the EXE, MEM and WB entries, bit0 = EXE
stall_count  out  CNT_W  number of hazard cycles, saturating

Behaviour:
- Scoreboard state: three entries, E0 = EXE, E1 = MEM, E2 = WB. Each entry holds {valid, wb, mem_r, s, dest[3:0]}.
- Per-entry RAW match: m_k = valid_k & wb_k & ((dest_k == src1) | (two_src & dest_k == src2)).
- RAW hazard, FORWARD_EN = 0: raw = m_0 | m_1 | (m_2 & ~WB_BYPASS).
- RAW hazard, FORWARD_EN = 1: raw = m_0 & mem_r_0.
- Status hazard: sh = id_uses_status & valid_0 & s_0. This applies regardless of the parameters, because the status register is written at the end of EXE.
- hazard = id_valid & ~flush & (raw | sh). It is purely combinational, with zero latency, and is evaluated even while frozen.
- Rising edge, priority order:
  - rst: clear all entries; stall_count = 0.
  - else freeze: hold every entry and stall_count.
  - else shift: E2 <= E1; E1 <= E0.
  - E0 <= {1, id_wb_en, id_mem_r_en, id_s, id_dest} only when id_valid & ~flush & ~hazard; otherwise E0 <= all-zero (bubble).
  - stall_count increments when hazard & ~freeze, and saturates at all-ones.
- Reset values: entries 0, so pend_valid = 3'b000, hazard = 0, stall_count = 0.
- Boundary conditions:
  - src1 and src2 matching the same entry count once.
  - R15 is treated like any other register.
  - An ID instruction with id_wb_en = 0 still stalls if its sources match.
  - flush together with freeze: state is held. The flush source must keep flush asserted until freeze drops.
  - Reset mid-stall: the hazard clears on the next cycle.
  - A pending entry with dest = 0 and wb = 0 never matches.

Decomposition:
- Shared package: sb_entry_t struct {valid, wb, mem_r, s, dest}; stage-index constants STG_EXE = 0, STG_MEM = 1, STG_WB = 2; the bubble constant SB_BUBBLE.
- One sub-module, sb_entry_match: combinational per-entry RAW comparator, instantiated three times.

Test Plan:
1. FORWARD_EN = 0, WB_BYPASS = 0: issue ADD R1 (wb = 1, dest = 1) at cycle 0; SUB with src1 = 1 in ID from cycle 1 -> hazard = 1 in cycles 1-3, SUB enters EXE at the cycle-4 edge, stall_count = 3.
2. Same as 1 with WB_BYPASS = 1 -> hazard for 2 cycles only; with FORWARD_EN = 1 -> no stall for ADD; LDR R1 instead -> exactly 1 hazard cycle.
3. CMP (s = 1) followed by MOVEQ (id_uses_status = 1) -> hazard for 1 cycle; same with id_uses_status = 0 -> no hazard.
4. freeze = 1 for 4 cycles while E0 = R2 writer and ID reads R2 -> pend_valid is stable, hazard stays 1, stall_count does not increment; after release the stall resolves normally.
5. flush = 1 with a matching ID instruction -> hazard = 0 and a bubble enters E0 (pend_valid[0] = 0 next cycle).
6. CNT_W = 2 with a continuous 6-cycle dependency chain -> stall_count goes 1, 2, 3, 3; rst asserted mid-sequence -> pend_valid = 0, stall_count = 0 the next cycle.
